// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Registered issue/capture wrapper around a purely combinational ALU.
// Requests {a, b, mode} enter a DEPTH-entry FIFO over a valid/ready
// handshake. The FIFO head is presented to the ALU combinationally. The
// ALU's result/carry is captured into a single output slot, which is
// drained over a second valid/ready handshake. Results leave in request
// order.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      request handshake (in_ready = count < DEPTH)
//   in_a, in_b, in_mode      request operands and 4-bit ALU operation
//   alu_a, alu_b, alu_sel    head entry to the ALU (all zero when empty)
//   alu_result, alu_carry    combinational return from the ALU
//   out_valid / out_ready    result handshake
//   out_result, out_carry    captured ALU result and carry
//   count                    FIFO occupancy, not counting the output slot
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [3:0]                 in_mode,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [3:0]                 alu_sel,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_carry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_a    [DEPTH];
    logic [WIDTH-1:0] mem_b    [DEPTH];
    logic [3:0]       mem_mode [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic empty;
    logic push;
    logic pop;
    logic slot_free;

    // in_ready looks only at the registered count, so a pop in the same
    // cycle never raises it; this keeps out_ready off the in_ready path.
    assign empty     = (count == '0);
    assign in_ready  = (count < FULL_COUNT);
    assign push      = in_valid & in_ready;
    assign slot_free = ~out_valid | out_ready;
    assign pop       = ~empty & slot_free;

    // The head entry drives the ALU directly. Storage is not reset, so an
    // empty FIFO forces zeros rather than exposing stale entries.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (!empty) begin
            alu_a   = mem_a[rd_ptr];
            alu_b   = mem_b[rd_ptr];
            alu_sel = mem_mode[rd_ptr];
        end
    end

    // FIFO storage. It has no reset because the count and pointers alone
    // decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]    <= in_a;
            mem_b[wr_ptr]    <= in_b;
            mem_mode[wr_ptr] <= in_mode;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output slot. A pop refills it in the same edge that the old result
    // is consumed. When nothing is queued, consumption only clears
    // out_valid, and the data holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_carry  <= alu_carry;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Testbench for alu_issue_stage. It supplies a combinational ALU, runs
// directed scenarios with hand-computed results, and then runs randomized
// traffic. A queue-based model of the request FIFO and the output slot is
// compared against the DUT on every cycle outside reset.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [3:0]       in_mode = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic [CW-1:0]    count;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  mode;
    } req_t;

    // Reference state: pending requests plus the output slot contents.
    req_t        mq[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_res   = '0;
    logic        m_carry = 1'b0;
    logic        m_push;
    logic        m_pop;
    logic [32:0] m_alu;

    // Results the DUT hands over, stored as {carry, result}.
    logic [32:0] dut_log[$];

    always #5 clk = ~clk;

    // Behaviour of the ALU: SUB carry is the borrow (a < b). Undefined
    // encodings produce zero.
    function automatic logic [32:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  m);
        logic [32:0] r;
        r = '0;
        case (m)
            OP_ADD: r = {1'b0, a} + {1'b0, b};
            OP_SUB: begin r[31:0] = a - b; r[32] = (a < b); end
            OP_AND: r[31:0] = a & b;
            OP_OR:  r[31:0] = a | b;
            OP_XOR: r[31:0] = a ^ b;
            OP_SLL: r[31:0] = a << b[4:0];
            OP_SRL: r[31:0] = a >> b[4:0];
            OP_MUL: r[31:0] = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_sel);

    alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .count      (count)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Model update. A request is accepted while fewer than DEPTH are
    // queued. The oldest request moves into the slot whenever the slot is
    // empty or is being consumed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_res   = '0;
            m_carry = 1'b0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = (mq.size() != 0) && (!m_valid || out_ready);
            if (m_pop) begin
                m_alu   = alu_ref(mq[0].a, mq[0].b, mq[0].mode);
                m_res   = m_alu[31:0];
                m_carry = m_alu[32];
                m_valid = 1'b1;
                void'(mq.pop_front());
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (m_push) begin
                mq.push_back('{a: in_a, b: in_b, mode: in_mode});
            end
        end
    end

    // Per-cycle comparison on the falling edge, plus logging of results
    // that the consumer will take on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("in_ready",   64'(in_ready),   64'(mq.size() < DEPTH));
            checkOutput("count",      64'(count),      64'(mq.size()));
            checkOutput("out_valid",  64'(out_valid),  64'(m_valid));
            checkOutput("out_result", 64'(out_result), 64'(m_res));
            checkOutput("out_carry",  64'(out_carry),  64'(m_carry));
            checkOutput("alu_a",   64'(alu_a),   (mq.size() != 0) ? 64'(mq[0].a)    : 64'd0);
            checkOutput("alu_b",   64'(alu_b),   (mq.size() != 0) ? 64'(mq[0].b)    : 64'd0);
            checkOutput("alu_sel", 64'(alu_sel), (mq.size() != 0) ? 64'(mq[0].mode) : 64'd0);
            if (out_valid && out_ready) begin
                dut_log.push_back({out_carry, out_result});
            end
        end
    end

    // Holds one request until it is accepted, waiting a bounded number of
    // cycles for in_ready. Leaves in_valid asserted for back-to-back use.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] m);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("push_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic checkLog(input string name, input int idx, input logic [32:0] expected);
        checkOutput(name, (idx < dut_log.size()) ? 64'(dut_log[idx]) : 64'h1_DEAD_BEEF,
                    64'(expected));
    endtask

    initial begin
        logic [32:0] exp_stream [4];
        int accepted;

        exp_stream[0] = {1'b1, 32'hFFFF_FFFE};
        exp_stream[1] = {1'b0, 32'h0000_F000};
        exp_stream[2] = {1'b0, 32'h8000_0000};
        exp_stream[3] = {1'b0, 32'd12};

        // Reset release away from the clock edge.
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_count",     64'(count),     64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);

        // Single ADD with a carry out: valid one edge after acceptance,
        // then gone on the following edge.
        $display("[TB] single ADD");
        out_ready = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 32'd1, OP_ADD);
        in_valid = 1'b0;
        checkOutput("add_not_yet_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput("add_valid",  64'(out_valid),  64'd1);
        checkOutput("add_result", 64'(out_result), 64'd0);
        checkOutput("add_carry",  64'(out_carry),  64'd1);
        @(posedge clk); #1;
        checkOutput("add_valid_drop", 64'(out_valid), 64'd0);

        // Ordered back-to-back stream.
        $display("[TB] ordered stream");
        dut_log.delete();
        applyStimulus(32'd5, 32'd7, OP_SUB);
        applyStimulus(32'h0000_F0F0, 32'h0000_FF00, OP_AND);
        applyStimulus(32'd1, 32'd31, OP_SLL);
        applyStimulus(32'd3, 32'd4, OP_MUL);
        idleCycles(5);
        checkOutput("stream_len", 64'(dut_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkLog("stream_item", i, exp_stream[i]);
        end

        // Backpressure: one result in the slot plus DEPTH queued.
        $display("[TB] backpressure");
        dut_log.delete();
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 32'd100;
            in_b     = 32'(i);
            in_mode  = OP_ADD;
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("bp_accepted",  64'(accepted),   64'd5);
        checkOutput("bp_in_ready",  64'(in_ready),   64'd0);
        checkOutput("bp_count",     64'(count),      64'd4);
        checkOutput("bp_out_valid", 64'(out_valid),  64'd1);
        checkOutput("bp_out_first", 64'(out_result), 64'd100);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
        checkOutput("bp_count_pop",  64'(count),    64'd3);
        idleCycles(8);
        checkOutput("bp_len", 64'(dut_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            checkLog("bp_item", i, 33'(100 + i));
        end

        // Simultaneous push and pop at count 2.
        $display("[TB] push and pop together");
        out_ready = 1'b0;
        applyStimulus(32'd10, 32'd1, OP_ADD);
        applyStimulus(32'd20, 32'd2, OP_ADD);
        applyStimulus(32'd30, 32'd3, OP_ADD);
        checkOutput("pp_count_before",  64'(count),      64'd2);
        checkOutput("pp_result_before", 64'(out_result), 64'd11);
        out_ready = 1'b1;
        applyStimulus(32'd40, 32'd4, OP_ADD);
        checkOutput("pp_count_after",  64'(count),      64'd2);
        checkOutput("pp_result_after", 64'(out_result), 64'd22);
        checkOutput("pp_valid_after",  64'(out_valid),  64'd1);
        idleCycles(6);

        // Undefined operation encoding passes through and yields zero.
        $display("[TB] undefined mode");
        dut_log.delete();
        applyStimulus(32'd7, 32'd9, 4'hF);
        idleCycles(4);
        checkOutput("illegal_len", 64'(dut_log.size()), 64'd1);
        checkLog("illegal_item", 0, 33'd0);

        // Asynchronous reset in the middle of a cycle with work queued.
        $display("[TB] mid-stream reset");
        dut_log.delete();
        out_ready = 1'b0;
        applyStimulus(32'd1, 32'd1, OP_ADD);
        applyStimulus(32'd2, 32'd2, OP_ADD);
        applyStimulus(32'd3, 32'd3, OP_ADD);
        applyStimulus(32'd4, 32'd4, OP_ADD);
        in_valid = 1'b0;
        checkOutput("pre_rst_count", 64'(count),     64'd3);
        checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid",  64'(out_valid),  64'd0);
        checkOutput("arst_count",      64'(count),      64'd0);
        checkOutput("arst_in_ready",   64'(in_ready),   64'd1);
        checkOutput("arst_out_result", 64'(out_result), 64'd0);
        checkOutput("arst_alu_a",      64'(alu_a),      64'd0);
        checkOutput("arst_alu_sel",    64'(alu_sel),    64'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        idleCycles(6);
        checkOutput("no_stale_results", 64'(dut_log.size()), 64'd0);

        // Randomized traffic with bursts of backpressure.
        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            in_mode   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                                    : 4'($urandom_range(0, 7));
            out_ready = ((i / 64) % 3 == 2) ? ($urandom_range(0, 5) == 0)
                                            : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idleCycles(10);
        checkOutput("final_count", 64'(count),     64'd0);
        checkOutput("final_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand issue and result capture stage wrapped around the combinational 32-bit ALU. It accepts {a, b, sel_mode} requests over a valid/ready handshake into a DEPTH-entry FIFO. It presents the head entry to the ALU's combinational inputs and registers the ALU's result/carry into a single output slot. That slot is drained over a second valid/ready handshake. The block gives the purely combinational ALU a registered, back-pressurable pipeline boundary on both sides.

## Interface
- WIDTH, 32, operand/result width; must match the ALU instance.
- DEPTH, 4, request FIFO entries; power of two, ≥ 2.
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  request present
- in_ready  output  1  FIFO can accept; = (count < DEPTH), registered state only
- in_a, in_b  input  WIDTH  operands
- in_mode  input  alu_mode (4)  operation, alu_mode enum from alu_modes.sv
- alu_a, alu_b  output  WIDTH  head operands to ALU; 0 when FIFO empty
- alu_sel  output  alu_mode  head operation to ALU; ALU_ADD encoding... driven as 0 when empty
- alu_result  input  WIDTH  ALU result (combinational return)
- alu_carry  input  1  ALU carry (combinational return)
- out_valid  output  1  output slot holds a result
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  captured result
- out_carry  output  1  captured carry
- count  output  $clog2(DEPTH)+1  FIFO occupancy (excludes output slot)

## Operation
- push = in_valid & in_ready; FIFO written at wr_ptr, wr_ptr wraps modulo DEPTH.
- Head entry (rd_ptr) drives alu_a/alu_b/alu_sel combinationally from storage; no operand modification.
- slot_free = !out_valid | out_ready.
- pop = (count != 0) & slot_free. On pop, out_result ← alu_result, out_carry ← alu_carry, out_valid ← 1, rd_ptr advances.
- If out_valid & out_ready & (count == 0), then out_valid ← 0; out_result/out_carry hold their last value.
- count next = count + push − pop; push and pop in the same cycle leave count unchanged.
- in_ready derives from registered count only. When full, a same-cycle pop does not raise in_ready, so there is no combinational out_ready→in_ready path.
- out_valid, once high, stays high and out_result/out_carry stay stable until the cycle out_ready is sampled high.
- Undefined sel_mode encodings are passed to the ALU unchanged. The ALU returns result 0, carry 0, which is captured like any other result.
- Results leave in strict request order.
- Reset (async assert, any time, including mid-transfer): count=0, pointers=0, out_valid=0, out_result=0, out_carry=0. Therefore in_ready=1 and alu_a=alu_b=alu_sel=0. In-flight requests are discarded. Deassertion is taken synchronously; first push possible on the first rising edge after rst_n high.

## Timing
- Latency: request accepted on edge k with FIFO and slot empty → out_valid high after edge k+1 with its result.
- Throughput: one request per cycle sustained while out_ready=1 and in_valid=1; count stays at 1.
- Backpressure: with out_ready=0, slot holds 1 result and the FIFO fills. in_ready drops after DEPTH further accepts, so DEPTH+1 requests are buffered in total.
- Full FIFO, out_ready rises on edge j: pop on edge j, in_ready high after edge j.
- Carry is valid only for ADD/SUB; it is 0 for all other modes (ALU behaviour, captured as-is).

## Test plan
- Reset: drive rst_n=0 mid-stream with 3 entries queued and out_valid=1 → immediately out_valid=0, count=0, in_ready=1, out_result=0; after release, no stale results appear.
- Single ADD: a=0xFFFF_FFFF, b=1, ADD accepted on edge k, out_ready=1 → out_valid after edge k+1, out_result=0, out_carry=1; out_valid drops next edge.
- Ordered stream: back-to-back SUB(5,7), AND(0xF0F0,0xFF00), SLL(1,31), MUL(3,4) with out_ready=1 → results 0xFFFF_FFFE carry=1, 0xF000, 0x8000_0000, 12, one per cycle in order.
- Backpressure/full: out_ready=0, push 6 requests → 5 accepted, in_ready low after 5th, count=DEPTH=4. Then out_ready=1 → 5 results drain in order; in_ready returns after first pop edge.
- Simultaneous push/pop at count=2 with out_valid=1 and out_ready=1 → count stays 2, out_result updates to next head.
- Illegal mode encoding 4'hF with a=7, b=9 → out_result=0, out_carry=0, handshake unaffected.
